// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush and bubble insertion.
// Control bits are zeroed whenever the stage holds no valid beat; data bits hold their last value.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 192,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy_o
);

  // state | meaning
  // EMPTY | no beat held, valid_o=0
  // ONE   | main entry valid
  // FULL  | main and skid entries valid, ready_o=0 (SKID=1 only)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic              in_xfer, out_xfer;

  assign valid_o     = (state != EMPTY);
  assign ctrl_o      = main_ctrl;
  assign data_o      = main_data;
  assign occupancy_o = state;

  generate
    if (SKID != 0) begin : g_skid
      assign ready_o = (state != FULL);
    end else begin : g_noskid
      assign ready_o = (state == EMPTY) | ready_i;
    end
  endgenerate

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;

  // Without a skid entry, ready_o already implies ready_i when ONE, so FULL is unreachable.
  always_comb begin
    state_nxt     = state;
    main_ctrl_nxt = main_ctrl;
    main_data_nxt = main_data;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;
    if (flush_i) begin
      state_nxt     = EMPTY;
      main_ctrl_nxt = '0;
      skid_ctrl_nxt = '0;
      skid_data_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt     = ONE;
            main_ctrl_nxt = ctrl_i;
            main_data_nxt = data_i;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl_nxt = ctrl_i;
            main_data_nxt = data_i;
          end else if (in_xfer) begin
            state_nxt     = FULL;
            skid_ctrl_nxt = ctrl_i;
            skid_data_nxt = data_i;
          end else if (out_xfer) begin
            state_nxt     = EMPTY;
            main_ctrl_nxt = '0;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt     = ONE;
            main_ctrl_nxt = skid_ctrl;
            main_data_nxt = skid_data;
            skid_ctrl_nxt = '0;
            skid_data_nxt = '0;
          end
        end
        default: begin
          state_nxt     = EMPTY;
          main_ctrl_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      main_ctrl <= main_ctrl_nxt;
      main_data <= main_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are each
// compared every cycle against a small FIFO-style model, plus directed literal checks.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 192;

  logic clk, rst_n, flush_i, valid_i, ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;

  logic          v1, r1, v0, r0;
  logic [CW-1:0] c1, c0;
  logic [DW-1:0] d1, d0;
  logic [1:0]    o1, o0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r1),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v1), .ready_i(ready_i),
    .ctrl_o(c1), .data_o(d1), .occupancy_o(o1));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r0),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v0), .ready_i(ready_i),
    .ctrl_o(c0), .data_o(d0), .occupancy_o(o0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // model: m=1 is the skid build (capacity 2), m=0 the single-entry build
  int            cnt    [2];
  logic [CW-1:0] q_ctrl [2][2];
  logic [DW-1:0] q_data [2][2];
  logic [DW-1:0] hold   [2];

  function automatic logic exp_ready(input int m);
    if (m == 1) return cnt[1] < 2;
    return (cnt[0] == 0) || ready_i;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int m);
    return (cnt[m] > 0) ? q_data[m][0] : hold[m];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0;
      hold[m] = '0;
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int m, input logic v, input logic [CW-1:0] c,
                     input logic [DW-1:0] d, input logic r, input logic [1:0] o);
    chk($sformatf("u%0d.valid_o", m), DW'(v), DW'(cnt[m] > 0));
    chk($sformatf("u%0d.ctrl_o", m), DW'(c), DW'((cnt[m] > 0) ? q_ctrl[m][0] : '0));
    chk($sformatf("u%0d.data_o", m), d, exp_data(m));
    chk($sformatf("u%0d.ready_o", m), DW'(r), DW'(exp_ready(m)));
    chk($sformatf("u%0d.occupancy_o", m), DW'(o), DW'(cnt[m]));
  endtask

  task automatic drv(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic r, input logic f);
    valid_i = v; ctrl_i = c; data_i = d; ready_i = r; flush_i = f;
  endtask

  // compare at negedge, advance model on the posedge, return at posedge+1
  task automatic tick();
    logic in_x [2];
    logic out_x[2];
    @(negedge clk);
    cmp(0, v0, c0, d0, r0, o0);
    cmp(1, v1, c1, d1, r1, o1);
    for (int m = 0; m < 2; m++) begin
      in_x[m]  = valid_i & exp_ready(m);
      out_x[m] = (cnt[m] > 0) & ready_i;
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (flush_i) begin
        hold[m] = exp_data(m);
        cnt[m]  = 0;
      end else begin
        if (out_x[m]) begin
          hold[m] = q_data[m][0];
          q_ctrl[m][0] = q_ctrl[m][1];
          q_data[m][0] = q_data[m][1];
          cnt[m]--;
        end
        if (in_x[m]) begin
          q_ctrl[m][cnt[m]] = ctrl_i;
          q_data[m][cnt[m]] = data_i;
          cnt[m]++;
        end
      end
    end
    #1;
  endtask

  // entered at posedge+1; asserts reset asynchronously and releases before the next negedge
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst.u1.valid", DW'(v1), '0);
    chk("rst.u1.ctrl",  DW'(c1), '0);
    chk("rst.u1.data",  d1, '0);
    chk("rst.u1.ready", DW'(r1), DW'(1));
    chk("rst.u1.occ",   DW'(o1), '0);
    chk("rst.u0.valid", DW'(v0), '0);
    chk("rst.u0.occ",   DW'(o0), '0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drv(1'b1, 8'hAA, DW'(32'h1234), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // back-to-back stream
    drv(1'b1, 8'h05, DW'(32'h100), 1'b1, 1'b0); tick();
    drv(1'b1, 8'h0A, DW'(32'h104), 1'b1, 1'b0);
    #1 chk("stream.A.valid", DW'(v1), DW'(1));
    chk("stream.A.ctrl", DW'(c1), DW'(8'h05));
    chk("stream.A.data", d1, DW'(32'h100));
    tick();
    drv(1'b0, 8'h00, '0, 1'b1, 1'b0);
    #1 chk("stream.B.ctrl", DW'(c1), DW'(8'h0A));
    chk("stream.B.data", d1, DW'(32'h104));
    chk("stream.B.occ", DW'(o1), DW'(1));
    tick();

    // bubble after an all-ones control beat
    drv(1'b1, 8'hFF, DW'(32'h200), 1'b1, 1'b0); tick();
    drv(1'b0, 8'h00, '0, 1'b1, 1'b0);
    #1 chk("bubble.A.ctrl", DW'(c1), DW'(8'hFF));
    tick();
    #1 chk("bubble.valid", DW'(v1), '0);
    chk("bubble.ctrl", DW'(c1), '0);
    chk("bubble.data", d1, DW'(32'h200));

    // stall fills main and skid, third beat waits upstream
    drv(1'b1, 8'h11, DW'(32'h300), 1'b0, 1'b0); tick();
    drv(1'b1, 8'h12, DW'(32'h304), 1'b0, 1'b0); tick();
    drv(1'b1, 8'h13, DW'(32'h308), 1'b0, 1'b0);
    #1 chk("stall.occ", DW'(o1), DW'(2));
    chk("stall.ready", DW'(r1), '0);
    chk("stall.ctrl", DW'(c1), DW'(8'h11));
    tick();
    drv(1'b1, 8'h13, DW'(32'h308), 1'b1, 1'b0);
    #1 chk("release.ready_reg", DW'(r1), '0);
    tick();
    #1 chk("release.B", DW'(c1), DW'(8'h12));
    chk("release.ready", DW'(r1), DW'(1));
    tick();
    drv(1'b0, 8'h00, '0, 1'b1, 1'b0);
    #1 chk("release.C", DW'(c1), DW'(8'h13));
    chk("release.C.data", d1, DW'(32'h308));
    tick();

    // flush with both entries full and a beat on the input
    drv(1'b1, 8'h21, DW'(32'h500), 1'b0, 1'b0); tick();
    drv(1'b1, 8'h22, DW'(32'h504), 1'b0, 1'b0); tick();
    drv(1'b1, 8'h23, DW'(32'h508), 1'b0, 1'b1); tick();
    drv(1'b0, 8'h00, '0, 1'b1, 1'b0);
    #1 chk("flush.valid", DW'(v1), '0);
    chk("flush.ctrl", DW'(c1), '0);
    chk("flush.occ", DW'(o1), '0);
    chk("flush.data_held", d1, DW'(32'h500));
    tick();
    #1 chk("flush.dropped", DW'(v1), '0);

    // single-entry build: ready follows ready_i in the same cycle
    drv(1'b1, 8'h31, DW'(32'h400), 1'b1, 1'b0); tick();
    drv(1'b1, 8'h32, DW'(32'h404), 1'b0, 1'b0);
    #1 chk("noskid.ready_stall", DW'(r0), '0);
    ready_i = 1'b1;
    #1 chk("noskid.ready_go", DW'(r0), DW'(1));
    tick();
    #1 chk("noskid.ctrl", DW'(c0), DW'(8'h32));
    chk("noskid.occ", DW'(o0), DW'(1));

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 9) < 7, CW'($urandom), rand_data(),
          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      tick();
      if (o0 > 2'd1) begin
        checks++;
        errors++;
        $display("FAIL noskid.occ_bound: got %0d expected <=1", o0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
